// File: rtl/kyber_ct_unmask_buffer.sv
// Masked ciphertext capture buffer: stores two Boolean shares apart and recombines them on host read.
// Latency: one cycle from rd_en to dout/dout_valid; capture accepts one share pair per cycle.
// Backpressure: none toward the core; extra valid_i outside CAPTURE is dropped and flags err.
`timescale 1ns/1ps
module kyber_ct_unmask_buffer #(
  parameter int DEPTH = 192,
  parameter int AW    = 8,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          valid_i,
  input  logic [DW-1:0] share0_i,
  input  logic [DW-1:0] share1_i,
  input  logic          rd_en,
  output logic [DW-1:0] dout,
  output logic          dout_valid,
  output logic          ct_ready,
  output logic          done,
  output logic          err,
  output logic [AW-1:0] wr_cnt
);

  typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN, FINISH} state_t;

  // Terminal address; pointers stop here as addresses, never relying on AW overflow.
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
  localparam logic [AW-1:0] ONE  = AW'(1);

  state_t        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic          ct_ready_q, ct_ready_d;
  logic          dout_valid_q, dout_valid_d;
  logic          err_q, err_d;
  logic [DW-1:0] dout_q;
  logic          wr_fire, rd_fire;

  // Each share lives in its own array; the two are never merged in storage.
  logic [DW-1:0] mem0_q [DEPTH];
  logic [DW-1:0] mem1_q [DEPTH];

  // Next-state and control decode; start overrides everything, including a coincident valid_i.
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    ct_ready_d   = ct_ready_q;
    dout_valid_d = 1'b0;
    err_d        = err_q;
    wr_fire      = 1'b0;
    rd_fire      = 1'b0;
    if (start) begin
      state_d    = CAPTURE;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      ct_ready_d = 1'b0;
      err_d      = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (valid_i) err_d = 1'b1;
        end
        CAPTURE: begin
          if (valid_i) begin
            wr_fire  = 1'b1;
            wr_ptr_d = wr_ptr_q + ONE;
            if (wr_ptr_q == LAST) begin
              state_d    = DRAIN;
              ct_ready_d = 1'b1;
            end
          end
        end
        DRAIN: begin
          if (valid_i) err_d = 1'b1;
          if (rd_en && (rd_ptr_q <= LAST)) begin
            rd_fire      = 1'b1;
            dout_valid_d = 1'b1;
            rd_ptr_d     = rd_ptr_q + ONE;
            if (rd_ptr_q == LAST) begin
              ct_ready_d = 1'b0;
              state_d    = FINISH;
            end
          end
        end
        FINISH: begin
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Control and output registers; the share XOR lands only in the output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      ct_ready_q   <= 1'b0;
      dout_valid_q <= 1'b0;
      err_q        <= 1'b0;
      dout_q       <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      ct_ready_q   <= ct_ready_d;
      dout_valid_q <= dout_valid_d;
      err_q        <= err_d;
      if (rd_fire) dout_q <= mem0_q[rd_ptr_q] ^ mem1_q[rd_ptr_q];
    end
  end

  // Share memory write port; contents need no reset.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem0_q[wr_ptr_q] <= share0_i;
      mem1_q[wr_ptr_q] <= share1_i;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign ct_ready   = ct_ready_q;
  assign done       = (state_q == FINISH);
  assign err        = err_q;
  assign wr_cnt     = wr_ptr_q;

endmodule

// File: doc/kyber_ct_unmask_buffer.md
Name: kyber_ct_unmask_buffer

Overview:
- Sits directly downstream of kyber_enc_core.
- Captures the 192-word masked ciphertext stream (two Boolean shares per word, qualified by the core's valid_o) into two separate share memories.
- Streams the recombined (share0 XOR share1) ciphertext to the host interface on a read-pull handshake.
- Shares are never combined in storage. Recombination happens only in the output register, at read time.

Parameters:
- DEPTH, 192, number of ciphertext words per encryption (Kyber-512 ct = 768 bytes).
- AW, 8, pointer width; must satisfy 2^AW >= DEPTH.
- DW, 32, word width of each share.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle pulse; arms the buffer for a new ciphertext and clears pointers.
- valid_i  input  1  share pair valid; connect to kyber_enc_core valid_o.
- share0_i  input  DW  share 0; connect to dout0.
- share1_i  input  DW  share 1; connect to dout1.
- rd_en  input  1  host read request, one word per asserted cycle.
- dout  output  DW  recombined ciphertext word (registered).
- dout_valid  output  1  dout holds a valid word this cycle.
- ct_ready  output  1  high while a full ciphertext is available to drain.
- done  output  1  one-cycle pulse after the last word is delivered.
- err  output  1  sticky protocol-violation flag.
- wr_cnt  output  AW  number of words captured so far.

Behaviour:
- Reset: all outputs are 0 (dout, dout_valid, ct_ready, done, err, wr_cnt). State=IDLE, wr_ptr=rd_ptr=0. Memory contents are don't-care.
- The FSM has four states: IDLE, CAPTURE, DRAIN, FINISH.
- IDLE:
  - start -> CAPTURE, wr_ptr<=0, rd_ptr<=0, err<=0.
  - valid_i -> ignored, err<=1.
  - rd_en -> ignored.
- CAPTURE:
  - Each cycle with valid_i=1 writes mem0[wr_ptr]<=share0_i and mem1[wr_ptr]<=share1_i, then wr_ptr increments. wr_cnt mirrors wr_ptr.
  - Back-to-back valid_i at one word per cycle must be accepted; there is no backpressure toward the core.
  - When the write at wr_ptr==DEPTH-1 occurs -> DRAIN next cycle, and ct_ready<=1 on the same edge.
  - rd_en is ignored; err is unaffected by it.
- DRAIN:
  - rd_en=1 with rd_ptr<DEPTH causes dout<=mem0[rd_ptr]^mem1[rd_ptr] and rd_ptr to increment. dout_valid is 1 in the cycle after rd_en (1-cycle read latency).
  - Otherwise dout_valid<=0 and dout holds its last value.
  - On the read of rd_ptr==DEPTH-1: ct_ready<=0 and state -> FINISH.
  - valid_i -> dropped, err<=1 (overflow).
- FINISH: lasts one cycle. done=1, and dout_valid=1 for the last word, coincident with done. Then -> IDLE.
- start in any state:
  - Restarts into CAPTURE with pointers cleared, ct_ready<=0, dout_valid<=0, err<=0.
  - Any partial capture or drain is abandoned.
  - start and valid_i in the same cycle: start wins and that sample is not written.
- Reset mid-operation returns immediately to the reset state. No partial data is reported as valid.
- Pointer wrap: pointers never exceed DEPTH-1 as an address. Terminal compare is on DEPTH-1, not on AW overflow.
- Memories may infer as simple dual-port RAM (one write port, one registered read port per share).
- The XOR is applied only to the registered read outputs, so no combined plaintext-domain value is stored.

Test Plan:
- Write 192 pairs with share0=k*0x01010101 and share1=0xA5A5A5A5^(k*0x01010101), then assert rd_en for 192 cycles. Required: every dout=0xA5A5A5A5, wr_cnt=192 before the drain, exactly 192 dout_valid pulses, and done on the cycle of the 192nd dout_valid.
- Feed valid_i with gaps (1 on, 3 off) from random shares. Required: captured order is preserved, ct_ready rises only after the 192nd write, and readback equals share0^share1 per index.
- In DRAIN, pulse rd_en every other cycle. Required: dout_valid follows rd_en by exactly one cycle, and dout is stable while dout_valid=0.
- Assert valid_i while in IDLE, and again during DRAIN. Required: err=1 and sticky until the next start; the memory is unchanged, so the drained data still matches.
- Issue start after 100 captured words, then send a fresh 192-word stream. Required: wr_cnt restarts at 0, the old words never appear, and only the new data is output.
- Assert rst mid-DRAIN (at rd_ptr=50). Required: all outputs are 0 immediately (asynchronous), and no done pulse follows until a new start-capture-drain cycle completes.
